// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame geometry and the default bit rate.
package uart_pkg;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_CLKS_PER_BIT = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } uart_rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; reset value selects the assumed idle level.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_deframer.sv
// 8N1 UART receive deframer: oversampled mid-bit sampling, single-entry holding register
// with valid/ready handshake, framing-error and overrun pulses.
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  input  logic       rx_enable,
  input  logic       rx_ready,
  output logic [7:0] rx_data_out,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_overrun
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int IDX_W    = $clog2(UART_DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

  uart_rx_state_t r_state;
  uart_rx_state_t w_next;

  logic [CNT_W-1:0]          r_cnt;
  logic [IDX_W-1:0]          r_bit_idx;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic                      r_rxd_prev;
  logic [7:0]                r_data;
  logic                      r_valid;
  logic                      r_frame_err;
  logic                      r_overrun;

  logic w_rxd_s;
  logic w_cnt_clr;
  logic w_sample_bit;
  logic w_byte_done;
  logic w_stop_bad;
  logic w_xfer;

  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_rxd_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .i_d  (rxd),
    .o_q  (w_rxd_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_rxd_prev <= 1'b1;
    end else begin
      r_state    <= w_next;
      r_rxd_prev <= w_rxd_s;
    end
  end

  // Start is edge-qualified so a line already low (break, or a frame joined mid-way) is ignored.
  always_comb begin
    w_next       = r_state;
    w_cnt_clr    = 1'b0;
    w_sample_bit = 1'b0;
    w_byte_done  = 1'b0;
    w_stop_bad   = 1'b0;
    if (!rx_enable) begin
      w_next    = IDLE;
      w_cnt_clr = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_rxd_s && r_rxd_prev) begin
            w_next    = START;
            w_cnt_clr = 1'b1;
          end
        end
        START: begin
          if (r_cnt == CNT_HALF) begin
            w_cnt_clr = 1'b1;
            w_next    = w_rxd_s ? IDLE : DATA;
          end
        end
        DATA: begin
          if (r_cnt == CNT_FULL) begin
            w_cnt_clr    = 1'b1;
            w_sample_bit = 1'b1;
            if (r_bit_idx == IDX_LAST) begin
              w_next = STOP;
            end
          end
        end
        STOP: begin
          if (r_cnt == CNT_FULL) begin
            w_cnt_clr = 1'b1;
            if (w_rxd_s) begin
              w_byte_done = 1'b1;
              w_next      = IDLE;
            end else begin
              w_stop_bad = 1'b1;
              w_next     = WAIT_HIGH;
            end
          end
        end
        WAIT_HIGH: begin
          if (w_rxd_s) begin
            w_next    = IDLE;
            w_cnt_clr = 1'b1;
          end
        end
        default: begin
          w_next    = IDLE;
          w_cnt_clr = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (r_state != IDLE && r_state != WAIT_HIGH) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (r_state != DATA) begin
        r_bit_idx <= '0;
      end else if (w_sample_bit) begin
        r_bit_idx <= r_bit_idx + IDX_W'(1);
      end
      if (w_sample_bit) begin
        r_shift[r_bit_idx] <= w_rxd_s;
      end
    end
  end

  assign w_xfer = r_valid & rx_ready;

  // A completed byte may reload the register only when it is empty or being drained this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data      <= 8'h00;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_stop_bad;
      r_overrun   <= w_byte_done & r_valid & ~w_xfer;
      if (w_byte_done && (!r_valid || w_xfer)) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (w_xfer) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_data_out  = r_data;
  assign rx_valid     = r_valid;
  assign rx_frame_err = r_frame_err;
  assign rx_overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Self-checking bench for uart_rx_deframer: directed vector table, hand-written corner cases,
// then random frames with random consumer back-pressure against a cycle-level slot model.
module tb_uart_rx_deframer;

  localparam int CPB  = 8;
  localparam int HALF = CPB / 2;
  // Stop mid-sample lands 2 sync cycles + 1 detect cycle + HALF + 9 bit times after the start edge;
  // the holding register shows the result on the following edge.
  localparam int DONE_LAT = 3 + HALF + 9 * CPB;

  logic       clk;
  logic       rst_n;
  logic       rxd;
  logic       rx_enable;
  logic       rx_ready;
  logic [7:0] rx_data_out;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_overrun;

  uart_rx_deframer #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rxd         (rxd),
    .rx_enable   (rx_enable),
    .rx_ready    (rx_ready),
    .rx_data_out (rx_data_out),
    .rx_valid    (rx_valid),
    .rx_frame_err(rx_frame_err),
    .rx_overrun  (rx_overrun)
  );

  typedef struct {
    logic [7:0] data;
    bit         good;
    int         readyMode;
    int         idleBits;
    bit         expValid;
    logic [7:0] expData;
    int         expErr;
    int         expOvr;
  } vec_t;

  typedef struct {
    int         doneCyc;
    logic [7:0] data;
    bit         good;
  } ev_t;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         errCnt = 0;
  int         ovrCnt = 0;
  bit         chkOn = 0;
  bit         randReady = 0;
  bit         mValid = 0;
  logic [7:0] mData = 8'h00;
  bit         mErr = 0;
  bit         mOvr = 0;
  ev_t        evQ[$];
  logic [7:0] modelAccQ[$];
  logic [7:0] dutAccQ[$];
  vec_t       vecs[6];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (randReady) rx_ready = ($urandom_range(0, 99) < 35);
  endtask

  // Behavioural slot model: one byte slot, events arrive at their known completion cycle.
  always @(posedge clk or negedge rst_n) begin
    bit  xfer;
    ev_t ev;
    if (!rst_n) begin
      mValid = 0;
      mData  = 8'h00;
      mErr   = 0;
      mOvr   = 0;
      evQ.delete();
    end else begin
      cyc  = cyc + 1;
      xfer = mValid && rx_ready;
      mErr = 0;
      mOvr = 0;
      if (xfer) modelAccQ.push_back(mData);
      if (evQ.size() > 0 && evQ[0].doneCyc == cyc) begin
        ev = evQ.pop_front();
        if (!ev.good) begin
          mErr = 1;
          if (xfer) mValid = 0;
        end else if (!mValid || xfer) begin
          mData  = ev.data;
          mValid = 1;
        end else begin
          mOvr = 1;
        end
      end else if (xfer) begin
        mValid = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chkOn) begin
      checkOutput("model_valid", rx_valid, mValid);
      checkOutput("model_frame_err", rx_frame_err, mErr);
      checkOutput("model_overrun", rx_overrun, mOvr);
      if (mValid) checkOutput("model_data", rx_data_out, mData);
      if (rx_frame_err) errCnt++;
      if (rx_overrun) ovrCnt++;
      if (rx_valid && rx_ready) dutAccQ.push_back(rx_data_out);
    end
  end

  task automatic sendFrame(input logic [7:0] b, input bit good, input bit logEv);
    rxd = 1'b0;
    if (logEv) evQ.push_back('{cyc + DONE_LAT, b, good});
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) tick();
    end
    rxd = good;
    repeat (CPB) tick();
    if (!good) repeat (40) tick();
    rxd = 1'b1;
  endtask

  task automatic applyStimulus(input vec_t v);
    int err0;
    int ovr0;
    err0 = errCnt;
    ovr0 = ovrCnt;
    if (v.readyMode == 1) begin
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
    end else begin
      rx_ready = (v.readyMode == 2);
    end
    sendFrame(v.data, v.good, 1'b1);
    repeat (v.idleBits * CPB) tick();
    @(negedge clk);
    checkOutput("tbl_valid", rx_valid, v.expValid);
    if (v.expValid) checkOutput("tbl_data", rx_data_out, v.expData);
    checkOutput("tbl_frame_err_count", errCnt - err0, v.expErr);
    checkOutput("tbl_overrun_count", ovrCnt - ovr0, v.expOvr);
    rx_ready = 1'b0;
    tick();
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got still running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] b;
    logic [7:0] dirAcc[5];
    int         err0;
    bit         good;

    vecs[0] = '{8'hA5, 1'b1, 0, 2, 1'b1, 8'hA5, 0, 0};
    vecs[1] = '{8'h3C, 1'b0, 1, 2, 1'b0, 8'h00, 1, 0};
    vecs[2] = '{8'h81, 1'b1, 0, 2, 1'b1, 8'h81, 0, 0};
    vecs[3] = '{8'h11, 1'b1, 1, 0, 1'b1, 8'h11, 0, 0};
    vecs[4] = '{8'h22, 1'b1, 0, 2, 1'b1, 8'h11, 0, 1};
    vecs[5] = '{8'h33, 1'b1, 2, 2, 1'b0, 8'h00, 0, 0};
    dirAcc  = '{8'hA5, 8'h81, 8'h11, 8'h33, 8'hF0};

    rst_n     = 1'b0;
    rxd       = 1'b1;
    rx_enable = 1'b1;
    rx_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_valid", rx_valid, 1'b0);
    checkOutput("reset_data", rx_data_out, 8'h00);
    checkOutput("reset_frame_err", rx_frame_err, 1'b0);
    checkOutput("reset_overrun", rx_overrun, 1'b0);
    rst_n = 1'b1;
    chkOn = 1'b1;
    repeat (2 * CPB) tick();

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

    // Short low glitch shorter than half a bit must be rejected silently.
    err0 = errCnt;
    rxd = 1'b0;
    repeat (3) tick();
    rxd = 1'b1;
    repeat (2 * CPB) tick();
    @(negedge clk);
    checkOutput("glitch_valid", rx_valid, 1'b0);
    checkOutput("glitch_frame_err_count", errCnt - err0, 0);
    tick();

    // Receiver disabled during bit 3 of 0x5A, re-enabled halfway into low bit 7.
    b = 8'h5A;
    rxd = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      if (i == 3) rx_enable = 1'b0;
      rxd = b[i];
      if (i == 7) begin
        repeat (CPB / 2) tick();
        rx_enable = 1'b1;
        repeat (CPB / 2) tick();
      end else begin
        repeat (CPB) tick();
      end
    end
    rxd = 1'b1;
    repeat (3 * CPB) tick();
    @(negedge clk);
    checkOutput("enable_abort_valid", rx_valid, 1'b0);
    tick();
    sendFrame(8'hF0, 1'b1, 1'b1);
    repeat (CPB) tick();
    @(negedge clk);
    checkOutput("after_enable_valid", rx_valid, 1'b1);
    checkOutput("after_enable_data", rx_data_out, 8'hF0);
    tick();
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    tick();

    // Reset asserted inside the stop bit of 0x77 while 0x44 is still held.
    sendFrame(8'h44, 1'b1, 1'b1);
    repeat (CPB) tick();
    @(negedge clk);
    checkOutput("pre_reset_valid", rx_valid, 1'b1);
    checkOutput("pre_reset_data", rx_data_out, 8'h44);
    tick();
    b = 8'h77;
    rxd = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) tick();
    end
    rxd = 1'b1;
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_valid", rx_valid, 1'b0);
    checkOutput("midreset_data", rx_data_out, 8'h00);
    checkOutput("midreset_frame_err", rx_frame_err, 1'b0);
    checkOutput("midreset_overrun", rx_overrun, 1'b0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (4 * CPB) tick();
    @(negedge clk);
    checkOutput("post_reset_valid", rx_valid, 1'b0);
    tick();

    // Random frames with random consumer back-pressure.
    randReady = 1'b1;
    for (int n = 0; n < 40; n++) begin
      b    = 8'($urandom);
      good = ($urandom_range(0, 9) != 0);
      sendFrame(b, good, 1'b1);
      repeat ((good ? $urandom_range(0, 2) : $urandom_range(1, 2)) * CPB) tick();
    end
    randReady = 1'b0;
    rxd = 1'b1;
    repeat (2 * CPB) tick();
    rx_ready = 1'b1;
    repeat (3) tick();
    rx_ready = 1'b0;
    repeat (2) tick();

    checkOutput("accepted_count", dutAccQ.size(), modelAccQ.size());
    for (int i = 0; i < modelAccQ.size() && i < dutAccQ.size(); i++)
      checkOutput("accepted_byte", dutAccQ[i], modelAccQ[i]);
    for (int i = 0; i < 5; i++)
      checkOutput("directed_accepted", (i < dutAccQ.size()) ? 32'(dutAccQ[i]) : 32'hFFFF_FFFF,
                  32'(dirAcc[i]));

    chkOn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
Receive-side serial front end feeding the SRAM command controller's byte interface (rx_data_out / rx_valid / rx_ready / rx_enable). It synchronises the asynchronous serial line and deframes 8N1 UART frames (1 start, 8 data LSB-first, 1 stop) by oversampling. Each good byte is presented in a single-entry holding register under a valid/ready handshake. It flags framing errors and overruns to the top level.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit; legal range 4..65535.
HALF_BIT, CLKS_PER_BIT/2 (floor), cycles from start-edge detection to the start-bit mid-sample.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
rxd  input  1  asynchronous serial line; idle high
rx_enable  input  1  1 = receiver active; 0 = abort any frame and hold in IDLE
rx_ready  input  1  consumer accepts the byte this cycle when rx_valid=1
rx_data_out  output  8  received byte; stable while rx_valid=1
rx_valid  output  1  holding register full
rx_frame_err  output  1  one-cycle pulse: stop bit sampled low
rx_overrun  output  1  one-cycle pulse: good byte dropped because holding register full

Behaviour:
- Clock/reset: the block uses a single clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - rx_data_out = 8'h00; rx_valid, rx_frame_err and rx_overrun = 0.
  - FSM in IDLE; bit counter and divide counter = 0.
  - Both synchroniser flops = 1 (line idle).
- Synchroniser: rxd passes through 2 flops. All decisions use the second flop (rxd_s). This gives 2 cycles of input latency.
- Divide counter: width clog2(CLKS_PER_BIT). Reloaded on every state entry and counts up to its target. No free-running timebase.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: rxd_s=0 and rx_enable=1 -> START, counter cleared.
  - START: at count HALF_BIT-1, sample rxd_s.
    - 0 -> DATA, with bit index 0 and counter cleared.
    - 1 -> IDLE (false start or glitch; no flags).
  - DATA: every CLKS_PER_BIT cycles, sample rxd_s into shift[bit_idx] (LSB first).
    - After bit 7 is sampled -> STOP.
  - STOP: at CLKS_PER_BIT cycles, sample rxd_s.
    - 1 -> byte complete; deliver it (see holding rules) and go to IDLE.
    - 0 -> pulse rx_frame_err for 1 cycle, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rxd_s=1, then IDLE. A break condition must not generate repeated frames.
- Holding register / handshake:
  - Transfer occurs on any cycle with rx_valid & rx_ready. The cycle after a transfer, rx_valid=0 unless a reload happened.
  - Byte complete with rx_valid=0: load rx_data_out and set rx_valid=1 on the next edge. Latency is 1 cycle after the stop-bit mid-sample.
  - Byte complete with rx_valid=1 and transfer in the same cycle: load the new byte; rx_valid stays 1.
  - Byte complete with rx_valid=1 and no transfer: drop the new byte, keep the old byte, pulse rx_overrun for 1 cycle.
  - rx_valid never deasserts without a transfer, except on reset.
- rx_enable=0:
  - FSM is forced to IDLE within 1 cycle and the partial frame is discarded; no flags.
  - The holding register and rx_valid are unaffected, so a pending byte can still be drained.
- A frame in progress when rx_enable rises is ignored until the line has been seen in IDLE. Entry to START is edge-qualified: rxd_s was 1 on the previous cycle.
- rx_frame_err and rx_overrun are mutually exclusive and never assert in the same cycle as reset release.
- Reset mid-frame: outputs take their reset values immediately; after release the block waits for a high-to-low edge.

Decomposition:
- Shared package uart_pkg holds:
  - the FSM state enum (uart_rx_state_t);
  - UART_DATA_BITS=8;
  - the default CLKS_PER_BIT constant, which is reused by the future TX serialiser.
- One natural sub-module: sync_2ff (parameterised reset value, 1-bit), instanced for rxd and reusable by other async inputs.

Test Plan:
- CLKS_PER_BIT=8, send 0xA5 with rx_ready=0 -> rx_valid rises 1 cycle after the stop mid-sample, rx_data_out=0xA5 and held; pulse rx_ready 1 cycle -> rx_valid=0 next cycle.
- Drive rxd low for 3 cycles (less than HALF_BIT=4), then high -> no rx_valid, no flags, FSM back in IDLE.
- Send 0x3C with the stop bit low, line held low 40 cycles, then a good 0x81 -> one rx_frame_err pulse, no byte for 0x3C, rx_data_out=0x81 delivered.
- Send 0x11 then 0x22 back-to-back with rx_ready=0 -> rx_overrun pulses once, rx_data_out stays 0x11; send 0x33 with rx_ready=1 held -> 0x11 and 0x33 are each accepted exactly once.
- Drop rx_enable during DATA bit 3 of 0x5A, re-raise it mid-frame -> no rx_valid for 0x5A; the next clean frame 0xF0 is received correctly.
- Assert rst_n=0 during the stop bit of 0x77 while rx_valid=1 (old byte) -> rx_valid=0 and rx_data_out=0x00 immediately; after release, no spurious byte.
